// File: rtl/iomem_audio_pkg.sv
// Register map, bit positions and STATUS packing shared by the audio FIFO block.
package iomem_audio_pkg;

    localparam logic [3:0] REG_DATA    = 4'h0;
    localparam logic [3:0] REG_STATUS  = 4'h4;
    localparam logic [3:0] REG_CTRL    = 4'h8;
    localparam logic [3:0] REG_LOWATER = 4'hC;

    localparam int ST_EMPTY_BIT    = 16;
    localparam int ST_FULL_BIT     = 17;
    localparam int ST_UNDERRUN_BIT = 18;
    localparam int ST_OVERFLOW_BIT = 19;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_FLUSH_BIT  = 2;

    // Field order mirrors the STATUS word from bit 19 down to bit 0.
    typedef struct packed {
        logic        overflow;
        logic        underrun;
        logic        full;
        logic        empty;
        logic [15:0] level;
    } status_t;

    function automatic logic [31:0] pack_status(input status_t st);
        return {12'h000, st};
    endfunction

    function automatic logic [1:0] reg_word(input logic [3:0] offset);
        return offset[3:2];
    endfunction

endpackage

// File: rtl/iomem_audio_fifo_sync_fifo.sv
// Single-clock circular FIFO with combinational head read and a synchronous flush.
module sync_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int LW = $clog2(DEPTH);
    localparam logic [LW-1:0] PTR_ONE  = LW'(1);
    localparam logic [LW:0]   LVL_ONE  = (LW + 1)'(1);
    localparam logic [LW:0]   LVL_FULL = (LW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [LW-1:0]    wr_ptr_q;
    logic [LW-1:0]    wr_ptr_d;
    logic [LW-1:0]    rd_ptr_q;
    logic [LW-1:0]    rd_ptr_d;
    logic [LW:0]      level_q;
    logic [LW:0]      level_d;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (level_q == {(LW + 1){1'b0}});
    assign full_o    = (level_q == LVL_FULL);
    assign level_o   = level_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign do_pop_s  = pop_i && !empty_o;
    assign do_push_s = push_i && (!full_o || do_pop_s);

    // Pointer and level next-state; flush wins over any concurrent push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = {LW{1'b0}};
            rd_ptr_d = {LW{1'b0}};
            level_d  = {(LW + 1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (do_push_s && !do_pop_s) begin
                level_d = level_q + LVL_ONE;
            end else if (do_pop_s && !do_push_s) begin
                level_d = level_q - LVL_ONE;
            end else begin
                level_d = level_q;
            end
        end
    end

    // Sample storage; left without reset so it maps onto RAM.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointer and level registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= {LW{1'b0}};
            rd_ptr_q <= {LW{1'b0}};
            level_q  <= {(LW + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/iomem_audio_fifo.sv
// iomem-mapped audio sample FIFO: register window, bus handshake, codec drain and refill interrupt.
module iomem_audio_fifo
    import iomem_audio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          DEPTH     = 64,
    parameter int          SAMPLE_W  = 16
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                iomem_valid,
    output logic                iomem_ready,
    input  logic [3:0]          iomem_wstrb,
    input  logic [31:0]         iomem_addr,
    input  logic [31:0]         iomem_wdata,
    output logic [31:0]         iomem_rdata,
    input  logic                sample_strobe,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                irq
);

    localparam int LW = $clog2(DEPTH);
    localparam logic [15:0] LOWATER_RST = 16'(DEPTH / 4);

    logic                ready_q;
    logic                ready_d;
    logic                enable_q;
    logic                enable_d;
    logic                irq_en_q;
    logic                irq_en_d;
    logic                underrun_q;
    logic                underrun_d;
    logic                overflow_q;
    logic                overflow_d;
    logic [15:0]         lowater_q;
    logic [15:0]         lowater_d;
    logic [SAMPLE_W-1:0] sample_q;
    logic [SAMPLE_W-1:0] sample_d;
    logic                irq_q;
    logic                irq_d;

    logic                sel_s;
    logic                access_s;
    logic                wr_s;
    logic                rd_s;
    logic [1:0]          word_s;
    logic                wr_data_s;
    logic                wr_status_s;
    logic                wr_ctrl_s;
    logic                wr_lowater_s;
    logic                push_s;
    logic                pop_s;
    logic                flush_s;
    logic [SAMPLE_W-1:0] fifo_rdata_s;
    logic [LW:0]         fifo_level_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;
    logic [15:0]         level16_s;
    status_t             status_s;
    logic [31:0]         rdata_s;
    logic                unused_s;

    assign unused_s = ^{iomem_addr[1:0], iomem_wdata};

    assign sel_s    = iomem_valid && (iomem_addr[31:4] == BASE_ADDR[31:4]);
    // The access completes in the ready cycle; writes commit on the edge that ends it.
    assign access_s = sel_s && ready_q;
    assign wr_s     = access_s && (iomem_wstrb != 4'b0000);
    assign rd_s     = access_s && (iomem_wstrb == 4'b0000);
    assign word_s   = iomem_addr[3:2];

    assign wr_data_s    = wr_s && (word_s == reg_word(REG_DATA));
    assign wr_status_s  = wr_s && (word_s == reg_word(REG_STATUS));
    assign wr_ctrl_s    = wr_s && (word_s == reg_word(REG_CTRL));
    assign wr_lowater_s = wr_s && (word_s == reg_word(REG_LOWATER));

    assign push_s  = wr_data_s;
    assign pop_s   = sample_strobe && enable_q;
    assign flush_s = wr_ctrl_s && iomem_wdata[CTRL_FLUSH_BIT];

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SAMPLE_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_n_i (resetn),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (flush_s),
        .wdata_i (iomem_wdata[SAMPLE_W-1:0]),
        .rdata_o (fifo_rdata_s),
        .level_o (fifo_level_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    assign level16_s         = 16'(fifo_level_s);
    assign status_s.overflow = overflow_q;
    assign status_s.underrun = underrun_q;
    assign status_s.full     = fifo_full_s;
    assign status_s.empty    = fifo_empty_s;
    assign status_s.level    = level16_s;

    // Read mux: data is only driven during the ready cycle of an in-window read.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (rd_s) begin
            if (word_s == reg_word(REG_STATUS)) begin
                rdata_s = pack_status(status_s);
            end else if (word_s == reg_word(REG_CTRL)) begin
                rdata_s = {29'h0000_0000, 1'b0, irq_en_q, enable_q};
            end else if (word_s == reg_word(REG_LOWATER)) begin
                rdata_s = {16'h0000, lowater_q};
            end else begin
                rdata_s = 32'h0000_0000;
            end
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    // Next-state for handshake, control, flags, codec sample and interrupt.
    always_comb begin
        ready_d   = sel_s && !ready_q;
        enable_d  = wr_ctrl_s ? iomem_wdata[CTRL_ENABLE_BIT] : enable_q;
        irq_en_d  = wr_ctrl_s ? iomem_wdata[CTRL_IRQ_EN_BIT] : irq_en_q;
        lowater_d = wr_lowater_s ? iomem_wdata[15:0] : lowater_q;
        // A new event outranks a software clear landing in the same cycle.
        underrun_d = (underrun_q && !(wr_status_s && iomem_wdata[ST_UNDERRUN_BIT]))
                   || (pop_s && fifo_empty_s);
        overflow_d = (overflow_q && !(wr_status_s && iomem_wdata[ST_OVERFLOW_BIT]))
                   || (push_s && fifo_full_s && !pop_s);
        if (pop_s) begin
            sample_d = fifo_empty_s ? {SAMPLE_W{1'b0}} : fifo_rdata_s;
        end else begin
            sample_d = sample_q;
        end
        irq_d = irq_en_q && ((level16_s < lowater_q) || underrun_q);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q    <= 1'b0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
            underrun_q <= 1'b0;
            overflow_q <= 1'b0;
            lowater_q  <= LOWATER_RST;
            sample_q   <= {SAMPLE_W{1'b0}};
            irq_q      <= 1'b0;
        end else begin
            ready_q    <= ready_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
            underrun_q <= underrun_d;
            overflow_q <= overflow_d;
            lowater_q  <= lowater_d;
            sample_q   <= sample_d;
            irq_q      <= irq_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_s;
    assign sample_out  = sample_q;
    assign irq         = irq_q;

endmodule

// File: tb/tb_iomem_audio_fifo.sv
// Directed bench for iomem_audio_fifo with a queue-based reference model checked every cycle.
module tb_iomem_audio_fifo;

    localparam logic [31:0] BASE  = 32'h0300_0000;
    localparam int          DEPTH = 64;
    localparam logic [31:0] A_DATA    = 32'h0300_0000;
    localparam logic [31:0] A_STATUS  = 32'h0300_0004;
    localparam logic [31:0] A_CTRL    = 32'h0300_0008;
    localparam logic [31:0] A_LOWATER = 32'h0300_000C;

    logic        clk = 1'b0;
    logic        resetn;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        sample_strobe;
    logic [15:0] sample_out;
    logic        irq;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    iomem_audio_fifo #(
        .BASE_ADDR (BASE),
        .DEPTH     (DEPTH),
        .SAMPLE_W  (16)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .iomem_valid   (iomem_valid),
        .iomem_ready   (iomem_ready),
        .iomem_wstrb   (iomem_wstrb),
        .iomem_addr    (iomem_addr),
        .iomem_wdata   (iomem_wdata),
        .iomem_rdata   (iomem_rdata),
        .sample_strobe (sample_strobe),
        .sample_out    (sample_out),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO contents as a queue, registers as plain variables.
    logic [15:0] mq[$];
    logic        m_ready = 1'b0;
    logic        m_en = 1'b0;
    logic        m_irq_en = 1'b0;
    logic        m_unf = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_irq = 1'b0;
    logic [15:0] m_low = 16'd16;
    logic [15:0] m_sample = 16'd0;

    always @(posedge clk) begin : model
        bit sel, wr, pop, n_irq;
        int idx;
        if (!resetn) begin
            mq.delete();
            m_ready = 1'b0; m_en = 1'b0; m_irq_en = 1'b0; m_unf = 1'b0;
            m_ovf = 1'b0; m_irq = 1'b0; m_low = 16'd16; m_sample = 16'd0;
        end else begin
            sel   = iomem_valid && (iomem_addr[31:4] == BASE[31:4]);
            wr    = sel && m_ready && (iomem_wstrb != 4'd0);
            idx   = int'(iomem_addr[3:2]);
            pop   = sample_strobe && m_en;
            n_irq = m_irq_en && ((mq.size() < int'(m_low)) || m_unf);
            m_ready = sel && !m_ready;
            if (wr && idx == 1) begin
                if (iomem_wdata[18]) m_unf = 1'b0;
                if (iomem_wdata[19]) m_ovf = 1'b0;
            end
            if (pop) begin
                if (mq.size() != 0) m_sample = mq.pop_front();
                else begin m_sample = 16'd0; m_unf = 1'b1; end
            end
            if (wr && idx == 0) begin
                if (mq.size() < DEPTH) mq.push_back(iomem_wdata[15:0]);
                else m_ovf = 1'b1;
            end
            if (wr && idx == 2) begin
                m_en = iomem_wdata[0];
                m_irq_en = iomem_wdata[1];
                if (iomem_wdata[2]) mq.delete();
            end
            if (wr && idx == 3) m_low = iomem_wdata[15:0];
            m_irq = n_irq;
        end
    end

    function automatic logic [31:0] exp_rdata();
        logic [31:0] r;
        int n;
        r = 32'd0;
        n = mq.size();
        if (m_ready && iomem_valid && (iomem_addr[31:4] == BASE[31:4]) && (iomem_wstrb == 4'd0)) begin
            case (iomem_addr[3:2])
                2'd1: r = 32'(n) | ((n == 0) ? 32'h0001_0000 : 32'd0) | ((n == DEPTH) ? 32'h0002_0000 : 32'd0)
                        | (m_unf ? 32'h0004_0000 : 32'd0) | (m_ovf ? 32'h0008_0000 : 32'd0);
                2'd2: r = {30'd0, m_irq_en, m_en};
                2'd3: r = {16'd0, m_low};
                default: r = 32'd0;
            endcase
        end
        return r;
    endfunction

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("ready", 32'(iomem_ready), 32'(m_ready));
            check("rdata", iomem_rdata, exp_rdata());
            check("sample_out", 32'(sample_out), 32'(m_sample));
            check("irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                            input bit strobe_at_commit, output logic [31:0] rd);
        int n;
        iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = wd;
        tick();
        n = 1;
        while (!iomem_ready && n < 8) begin
            tick();
            n++;
        end
        check("ready_latency", 32'(n), 32'd1);
        rd = iomem_rdata;
        if (strobe_at_commit) sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'd0;
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] wd);
        logic [31:0] rd;
        bus_xfer(addr, 4'hF, wd, 1'b0, rd);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        bus_xfer(addr, 4'h0, 32'd0, 1'b0, rd);
        check(name, rd, exp);
    endtask

    task automatic strobe();
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        resetn = 1'b0; iomem_valid = 1'b0; iomem_wstrb = 4'd0; iomem_addr = 32'd0;
        iomem_wdata = 32'd0; sample_strobe = 1'b0;
        repeat (3) tick();
        chk_en = 1'b1;
        check("rst_ready", 32'(iomem_ready), 32'd0);
        check("rst_rdata", iomem_rdata, 32'd0);
        check("rst_sample", 32'(sample_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        resetn = 1'b1;
        tick();
        rd_chk("rst_status", A_STATUS, 32'h0001_0000);
        rd_chk("rst_lowater", A_LOWATER, 32'd16);
        rd_chk("rst_ctrl", A_CTRL, 32'd0);

        // Single sample through the pipe.
        wr32(A_DATA, 32'h0000_1234);
        rd_chk("status_one", A_STATUS, 32'h0000_0001);
        wr32(A_CTRL, 32'd1);
        strobe();
        check("sample_1234", 32'(sample_out), 32'h0000_1234);
        rd_chk("status_drained", A_STATUS, 32'h0001_0000);

        // Underrun on an empty enabled FIFO.
        wr32(A_CTRL, 32'd3);
        strobe();
        check("sample_underrun", 32'(sample_out), 32'd0);
        tick();
        check("irq_underrun", 32'(irq), 32'd1);
        rd_chk("status_underrun", A_STATUS, 32'h0005_0000);
        wr32(A_STATUS, 32'h0004_0000);
        wr32(A_CTRL, 32'd0);
        rd_chk("status_unf_clr", A_STATUS, 32'h0001_0000);

        // Overfill by one, then clear overflow.
        for (int i = 0; i < 65; i++) wr32(A_DATA, 32'h0000_0100 + 32'(i));
        rd_chk("status_overflow", A_STATUS, 32'h000A_0040);
        wr32(A_STATUS, 32'h0008_0000);
        rd_chk("status_ovf_clr", A_STATUS, 32'h0002_0040);
        strobe();
        check("sample_held", 32'(sample_out), 32'd0);

        // Push into a full FIFO in the strobe cycle is legal.
        wr32(A_CTRL, 32'd1);
        bus_xfer(A_DATA, 4'hF, 32'h0000_BEEF, 1'b1, rd);
        check("sample_head", 32'(sample_out), 32'h0000_0100);
        rd_chk("status_full_pushpop", A_STATUS, 32'h0002_0040);
        wr32(A_CTRL, 32'd4);
        rd_chk("status_flushed", A_STATUS, 32'h0001_0000);
        rd_chk("ctrl_after_flush", A_CTRL, 32'd0);

        // Low-water interrupt and flush keeping irq high.
        wr32(A_LOWATER, 32'd4);
        wr32(A_CTRL, 32'd2);
        for (int i = 0; i < 5; i++) wr32(A_DATA, 32'h0000_0011 + 32'(i));
        tick();
        check("irq_filled", 32'(irq), 32'd0);
        wr32(A_CTRL, 32'd3);
        strobe();
        check("drain_first", 32'(sample_out), 32'h0000_0011);
        tick();
        check("irq_level4", 32'(irq), 32'd0);
        strobe();
        check("drain_second", 32'(sample_out), 32'h0000_0012);
        tick();
        check("irq_level3", 32'(irq), 32'd1);
        wr32(A_CTRL, 32'd7);
        rd_chk("status_flush2", A_STATUS, 32'h0001_0000);
        check("irq_after_flush", 32'(irq), 32'd1);

        // Outside the window nothing answers.
        iomem_valid = 1'b1; iomem_addr = 32'h0400_0004; iomem_wstrb = 4'd0;
        repeat (3) begin
            tick();
            check("oow_ready", 32'(iomem_ready), 32'd0);
            check("oow_rdata", iomem_rdata, 32'd0);
        end
        iomem_valid = 1'b0;
        tick();

        // Reset with ready already high drops the write.
        iomem_valid = 1'b1; iomem_addr = A_LOWATER; iomem_wstrb = 4'hF; iomem_wdata = 32'd8;
        tick();
        check("inflight_ready", 32'(iomem_ready), 32'd1);
        resetn = 1'b0;
        tick();
        check("reset_ready", 32'(iomem_ready), 32'd0);
        check("reset_irq", 32'(irq), 32'd0);
        resetn = 1'b1; iomem_valid = 1'b0; iomem_wstrb = 4'd0;
        tick();
        rd_chk("lowater_after_reset", A_LOWATER, 32'd16);
        rd_chk("status_after_reset", A_STATUS, 32'h0001_0000);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iomem_audio_fifo.md
# iomem_audio_fifo

Memory-mapped sample FIFO on the SoC `iomem` bus, downstream of the CPU's external-memory port (address space ≥ 0x0200_0000 not claimed by on-chip peripherals). Firmware pushes audio samples by word writes. The block drains one sample per `sample_strobe` pulse to the codec-side output register. A level-sensitive interrupt, intended for `irq_5`, requests refill when the FIFO runs low or underruns.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0300_0000 — register window base; 16-byte window.
- `DEPTH`, 64 — FIFO entries; power of two, ≥ 4.
- `SAMPLE_W`, 16 — sample width; ≤ 32.

Ports:
- `clk` in 1 — single clock.
- `resetn` in 1 — reset, synchronous, active-low.
- `iomem_valid` in 1 — bus request.
- `iomem_ready` out 1 — one-cycle acknowledge.
- `iomem_wstrb` in 4 — byte strobes; 0 means read.
- `iomem_addr` in 32 — byte address.
- `iomem_wdata` in 32 — write data.
- `iomem_rdata` out 32 — read data; valid while `iomem_ready` is high.
- `sample_strobe` in 1 — one-cycle pulse at the sample rate.
- `sample_out` out SAMPLE_W — current codec sample.
- `irq` out 1 — level interrupt.

## Operation
- Select: `sel = iomem_valid && iomem_addr[31:4] == BASE_ADDR[31:4]`. Outside the window the block never asserts `iomem_ready` and drives `iomem_rdata` = 0.
- Register map (word offsets):
  - 0x0 DATA, write-only. Any nonzero `wstrb` pushes `iomem_wdata[SAMPLE_W-1:0]`. Reads return 0.
  - 0x4 STATUS.
    - Read: [15:0] level, [16] empty, [17] full, [18] underrun, [19] overflow.
    - Write: 1 to bits 18/19 clears the matching flag.
  - 0x8 CTRL, R/W. [0] enable, [1] irq_en, [2] flush. Flush self-clears and empties the FIFO in the same cycle as the write. Flags are untouched.
  - 0xC LOWATER, R/W. [15:0] threshold; reset value DEPTH/4.
- Push when full: data dropped, overflow set. Exception: a pop in the same cycle makes the push legal.
- Pop occurs on `sample_strobe && enable`.
  - Not empty: `sample_out` <= head entry; level decrements.
  - Empty: `sample_out` <= 0 and underrun set. A push arriving in that same cycle is still stored.
- `sample_strobe` with enable = 0: no pop; `sample_out` is held.
- Simultaneous push and pop: level unchanged; pointers both advance.
- `irq` = registered `irq_en && (level < LOWATER || underrun)`.

## Timing
- Reset values: `iomem_ready` 0, `iomem_rdata` 0, `sample_out` 0, `irq` 0, level 0, all flags 0, CTRL 0, LOWATER DEPTH/4.
- Bus handshake:
  - `iomem_ready` <= `sel && !iomem_ready`.
  - A select in cycle N produces ready in N+1, for exactly one cycle.
  - The CPU holds its request until ready. Back-to-back accesses therefore take 2 cycles each.
- Writes commit on the clock edge that ends the ready cycle. Register reads sample state as of that same cycle.
- `sample_out` updates on the edge after the strobe cycle: one-cycle latency.
- `irq` lags its condition by one cycle.
- Reset asserted mid-transaction: all state returns to reset values at the next edge. An in-flight request with `iomem_ready` already registered high is dropped.
- Pointers use log2(DEPTH) bits and wrap modulo DEPTH. Level uses log2(DEPTH)+1 bits, range 0..DEPTH.

## Structure
- Package `iomem_audio_pkg`:
  - register offsets `REG_DATA`, `REG_STATUS`, `REG_CTRL`, `REG_LOWATER`;
  - STATUS and CTRL bit positions.
- Sub-module `sync_fifo`: parameters DEPTH and WIDTH.
  - Ports: push/pop/flush, wdata, rdata, level, full, empty.
  - Read is combinational from head; storage is inferred RAM.
- Top level: address decode, register file, handshake, flags, irq.

## Test plan
- Reset → all outputs 0; STATUS reads 0x0001_0000 (empty); LOWATER reads 16.
- Write 0x1234 to DATA, set enable, pulse strobe → `iomem_ready` in cycle N+1; `sample_out` = 0x1234 one cycle after the strobe; level 1 → 0.
- Push 65 samples with DEPTH 64 → level 64, full, overflow = 1. Write 0x80000 to STATUS → overflow cleared.
- Enable on empty FIFO, pulse strobe → `sample_out` = 0, underrun = 1, `irq` = 1 (with irq_en = 1) one cycle later.
- Full FIFO, DATA write commits in a strobe cycle → push accepted, level stays 64, no overflow.
- Set irq_en, LOWATER = 4, fill 5 and drain 2 → `irq` rises after level hits 3. Write flush → level 0, `irq` stays high because level 0 < LOWATER.
